// File: rtl/int_alu_pipe_pkg.sv
// Shared types for the pipelined integer ALU: function/mode encodings and the per-stage record.
// Optional feature macro used by this slice: ALU_PERF_CNT_EN.
`ifndef PHYS_REG_BITS
`define PHYS_REG_BITS 6
`endif

package int_alu_pipe_pkg;

  localparam int PHYS_REG_BITS = `PHYS_REG_BITS;
  localparam int XLEN_MAX      = 64;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_func_t;

  typedef enum logic [1:0] {
    ALU_MODE_NORMAL = 2'd0,
    ALU_MODE_LUI    = 2'd1,
    ALU_MODE_AUIPC  = 2'd2
  } alu_mode_t;

  // Sized for the widest datapath; narrower builds leave the upper result bits at zero.
  typedef struct packed {
    logic                     valid;
    logic [XLEN_MAX-1:0]      result;
    logic [PHYS_REG_BITS-1:0] tag;
    logic                     illegal;
  } alu_stage_t;

endpackage

// File: rtl/int_alu_pipe_if.sv
// Issue-side and CDB-side handshake bundle for int_alu_pipe.
// master = reservation station / CDB arbiter side, slave = the ALU unit.
interface int_alu_pipe_if
  import int_alu_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TAG_BITS = int_alu_pipe_pkg::PHYS_REG_BITS
);

  logic                issue_valid;
  logic                issue_ready;
  alu_func_t           issue_func;
  alu_mode_t           issue_mode;
  logic [XLEN-1:0]     issue_in1;
  logic [XLEN-1:0]     issue_in2;
  logic [XLEN-1:0]     issue_pc;
  logic [TAG_BITS-1:0] issue_tag;

  logic                cdb_valid;
  logic                cdb_ready;
  logic [XLEN-1:0]     cdb_result;
  logic [TAG_BITS-1:0] cdb_tag;
  logic                cdb_illegal;

  modport master (
    output issue_valid, issue_func, issue_mode, issue_in1, issue_in2, issue_pc, issue_tag,
    input  issue_ready,
    input  cdb_valid, cdb_result, cdb_tag, cdb_illegal,
    output cdb_ready
  );

  modport slave (
    input  issue_valid, issue_func, issue_mode, issue_in1, issue_in2, issue_pc, issue_tag,
    output issue_ready,
    output cdb_valid, cdb_result, cdb_tag, cdb_illegal,
    input  cdb_ready
  );

endinterface

// File: rtl/int_alu_pipe_alu_core.sv
// Purely combinational ALU datapath: {result, illegal} from func/mode/operands/pc.
module alu_core
  import int_alu_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_func_t       func,
  input  alu_mode_t       mode,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt_s;

  assign shamt_s = in2[SHW-1:0];

  // Operand select by mode, then function decode; undefined encodings yield 0 and flag illegal.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (mode)
      ALU_MODE_LUI:   result = in2;
      ALU_MODE_AUIPC: result = pc + in2;
      ALU_MODE_NORMAL: begin
        case (func)
          ALU_ADD:  result = in1 + in2;
          ALU_SUB:  result = in1 - in2;
          ALU_AND:  result = in1 & in2;
          ALU_OR:   result = in1 | in2;
          ALU_XOR:  result = in1 ^ in2;
          ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
          ALU_SLTU: result = {{(XLEN-1){1'b0}}, (in1 < in2)};
          ALU_SLL:  result = in1 << shamt_s;
          ALU_SRL:  result = in1 >> shamt_s;
          ALU_SRA:  result = $unsigned($signed(in1) >>> shamt_s);
          default: begin
            result  = '0;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        result  = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/int_alu_pipe.sv
// Pipelined integer ALU unit: valid/ready issue, STAGES-deep tag-carrying pipe, CDB back-pressure, flush.
// Define ALU_PERF_CNT_EN to add the perf_ops / perf_stall counters.
module int_alu_pipe
  import int_alu_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int STAGES   = 2,
  parameter int TAG_BITS = PHYS_REG_BITS
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  int_alu_pipe_if.slave bus
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [31:0]   perf_ops,
  output logic [31:0]   perf_stall
`endif
);

  alu_stage_t        stage_r [STAGES];
  alu_stage_t        issue_st_s;
  logic [STAGES-1:0] move_s;
  logic [XLEN-1:0]   core_result_s;
  logic              core_illegal_s;
  logic              cdb_valid_s;
  logic              issue_ready_s;
  logic              accept_s;

  alu_core #(.XLEN(XLEN)) u_core (
    .func    (bus.issue_func),
    .mode    (bus.issue_mode),
    .in1     (bus.issue_in1),
    .in2     (bus.issue_in2),
    .pc      (bus.issue_pc),
    .result  (core_result_s),
    .illegal (core_illegal_s)
  );

  assign cdb_valid_s   = stage_r[STAGES-1].valid & ~flush;
  assign issue_ready_s = ~reset & ~flush & (~stage_r[0].valid | move_s[0]);
  assign accept_s      = bus.issue_valid & issue_ready_s;

  // A stage moves on when the CDB takes it (last stage) or its successor is empty or moving.
  always_comb begin
    move_s           = '0;
    move_s[STAGES-1] = cdb_valid_s & bus.cdb_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      move_s[i] = stage_r[i].valid & (~stage_r[i+1].valid | move_s[i+1]);
    end
  end

  // Record that enters stage 0 on an accepted issue.
  always_comb begin
    issue_st_s         = '0;
    issue_st_s.valid   = 1'b1;
    issue_st_s.result  = XLEN_MAX'(core_result_s);
    issue_st_s.tag     = PHYS_REG_BITS'(bus.issue_tag);
    issue_st_s.illegal = core_illegal_s;
  end

  // Stage array: payload loads only on advance; flush clears valids, reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i].valid <= 1'b0;
      end
    end else begin
      if (accept_s) begin
        stage_r[0] <= issue_st_s;
      end else if (move_s[0]) begin
        stage_r[0].valid <= 1'b0;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (move_s[i-1]) begin
          stage_r[i] <= stage_r[i-1];
        end else if (move_s[i]) begin
          stage_r[i].valid <= 1'b0;
        end
      end
    end
  end

  assign bus.issue_ready = issue_ready_s;
  assign bus.cdb_valid   = cdb_valid_s;
  assign bus.cdb_result  = stage_r[STAGES-1].result[XLEN-1:0];
  assign bus.cdb_tag     = stage_r[STAGES-1].tag[TAG_BITS-1:0];
  assign bus.cdb_illegal = stage_r[STAGES-1].illegal;

`ifdef ALU_PERF_CNT_EN
  logic [31:0] perf_ops_r;
  logic [31:0] perf_stall_r;

  // Handshake and stall counters; survive flush, wrap naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_ops_r   <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      if (cdb_valid_s & bus.cdb_ready) begin
        perf_ops_r <= perf_ops_r + 32'd1;
      end
      if (cdb_valid_s & ~bus.cdb_ready) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_ops   = perf_ops_r;
  assign perf_stall = perf_stall_r;
`endif

endmodule
